// File: rtl/mem_stage_ctrl.sv
// Memory stage: takes EX bundles, runs the data-memory req/ack access, aligns load data, registers the WB bundle.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses skip memory and return a wb_misalign flag.
module mem_stage_ctrl #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            ex_reg_write,
  input  logic [1:0]      ex_result_src,
  input  logic            ex_mem_write,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_rd2,
  input  logic [XLEN-1:0] ex_pc_cur,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic            wb_reg_write,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_result,
  output logic            wb_timeout
`ifdef MISALIGN_TRAP_EN
  ,
  output logic            wb_misalign
`endif
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]   wait_cnt;
  logic            accept, is_mem, misal, tmo;
  logic [1:0]      off;
  logic [3:0]      be_c;
  logic [XLEN-1:0] wdata_c, ld_data;
  logic [7:0]      b_sel;
  logic [15:0]     h_sel;

  // pending load context, captured at accept and used when the ack returns
  logic [2:0]      p_f3;
  logic [1:0]      p_off;
  logic [4:0]      p_rd;
  logic            p_rw, p_ld;

  assign off      = ex_alu_result[1:0];
  assign ex_ready = (state == IDLE) && (!wb_valid || wb_ready);
  assign accept   = ex_valid && ex_ready;
  assign is_mem   = ex_mem_write || (ex_result_src == 2'b01);
  assign tmo      = (state == ACCESS) && !dmem_ack && (wait_cnt == CW'(MAX_WAIT - 1));

`ifdef MISALIGN_TRAP_EN
  assign misal = ((ex_funct3[1:0] == 2'b01) && off[0]) ||
                 ((ex_funct3[1:1] == 1'b1) && (off != 2'b00)) ||
                 ((ex_funct3[1:0] == 2'b11) && (off != 2'b00));
`else
  assign misal = 1'b0;
`endif

  // funct3[1:0]: 00 byte, 01 half, anything else treated as a word
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = ex_rd2;
    case (ex_funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << off;
        wdata_c = {(XLEN/8){ex_rd2[7:0]}};
      end
      2'b01: begin
        be_c    = off[1] ? 4'b1100 : 4'b0011;
        wdata_c = {(XLEN/16){ex_rd2[15:0]}};
      end
      default: ;
    endcase
  end

  assign b_sel = 8'(dmem_rdata >> {p_off, 3'b000});
  assign h_sel = 16'(dmem_rdata >> {p_off[1], 4'b0000});

  always_comb begin
    ld_data = dmem_rdata;
    case (p_f3)
      3'b000:  ld_data = {{(XLEN-8){b_sel[7]}}, b_sel};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, b_sel};
      3'b001:  ld_data = {{(XLEN-16){h_sel[15]}}, h_sel};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, h_sel};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_mem) state_nxt = misal ? HOLD : ACCESS;
      ACCESS:  if (dmem_ack || tmo) state_nxt = HOLD;
      HOLD:    if (wb_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt     <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_be      <= 4'b0000;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_result    <= '0;
      wb_timeout   <= 1'b0;
      p_f3         <= '0;
      p_off        <= '0;
      p_rd         <= '0;
      p_rw         <= 1'b0;
      p_ld         <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      wb_misalign  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (wb_valid && wb_ready) wb_valid <= 1'b0;
          if (accept) begin
            if (is_mem && !misal) begin
              dmem_req   <= 1'b1;
              dmem_we    <= ex_mem_write;
              dmem_addr  <= {ex_alu_result[XLEN-1:2], 2'b00};
              dmem_be    <= be_c;
              dmem_wdata <= wdata_c;
              wait_cnt   <= '0;
              p_f3       <= ex_funct3;
              p_off      <= off;
              p_rd       <= ex_rd;
              p_rw       <= ex_reg_write;
              p_ld       <= !ex_mem_write;
            end else begin
              wb_valid     <= 1'b1;
              wb_rd        <= ex_rd;
              wb_timeout   <= 1'b0;
              wb_reg_write <= is_mem ? 1'b0 : ex_reg_write;
              wb_result    <= is_mem ? '0 :
                              (ex_result_src == 2'b10) ? ex_pc_cur + XLEN'(4) : ex_alu_result;
`ifdef MISALIGN_TRAP_EN
              wb_misalign  <= is_mem;
`endif
            end
          end
        end
        ACCESS: begin
          if (dmem_ack || tmo) begin
            dmem_req     <= 1'b0;
            wb_valid     <= 1'b1;
            wb_rd        <= p_rd;
            wb_timeout   <= tmo;
            wb_reg_write <= dmem_ack && p_ld && p_rw;
            wb_result    <= (dmem_ack && p_ld) ? ld_data : '0;
`ifdef MISALIGN_TRAP_EN
            wb_misalign  <= 1'b0;
`endif
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        HOLD: if (wb_ready) wb_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized bench for mem_stage_ctrl against a transaction-level model of the stage.
module tb_mem_stage_ctrl;
  localparam int XLEN = 32, MAX_WAIT = 15;

  logic clk = 1'b0, reset = 1'b1;
  logic ex_valid = 0, ex_ready, ex_reg_write = 0, ex_mem_write = 0;
  logic [1:0] ex_result_src = 0;
  logic [2:0] ex_funct3 = 0;
  logic [4:0] ex_rd = 0;
  logic [31:0] ex_alu_result = 0, ex_rd2 = 0, ex_pc_cur = 0;
  logic dmem_req, dmem_we, dmem_ack = 0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 0;
  logic [3:0] dmem_be;
  logic wb_valid, wb_ready = 1, wb_reg_write, wb_timeout;
  logic [4:0] wb_rd;
  logic [31:0] wb_result;
`ifdef MISALIGN_TRAP_EN
  logic wb_misalign;
`endif

  int total = 0, bad = 0;

  mem_stage_ctrl #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_reg_write(ex_reg_write), .ex_result_src(ex_result_src), .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3), .ex_alu_result(ex_alu_result), .ex_rd(ex_rd), .ex_rd2(ex_rd2),
    .ex_pc_cur(ex_pc_cur), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_result(wb_result), .wb_timeout(wb_timeout)
`ifdef MISALIGN_TRAP_EN
    , .wb_misalign(wb_misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  // access size in bytes from funct3
  function automatic int sz_of(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input int off);
    int sz = sz_of(f3);
    int lane = (off / sz) * sz;
    return 4'(((1 << sz) - 1) << lane);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    int sz = sz_of(f3);
    if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input int off, input logic [31:0] w);
    int sz = sz_of(f3);
    int lane = (off / sz) * sz;
    logic [31:0] v = w >> (8 * lane);
    if (sz == 1) begin
      v = v & 32'hFF;
      if (f3 == 3'b000 && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (f3 == 3'b001 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // one instruction end to end; dly > MAX_WAIT means the memory never acks
  task automatic do_op(input logic rw, input logic [1:0] rs, input logic mw, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [4:0] rd, input logic [31:0] rd2,
                       input logic [31:0] pc, input int dly, input logic [31:0] rdata, input int stall);
    bit mem = mw || (rs == 2'b01);
    bit tmo = dly > MAX_WAIT;
    bit mis = 0;
    bit res_chk;
    int waits = 0;
    int n;
    int off = int'(alu[1:0]);
    logic [31:0] e_res = 0;
    logic e_rw = 0;
`ifdef MISALIGN_TRAP_EN
    mis = mem && ((off % sz_of(f3)) != 0);
`endif
    ex_reg_write = rw; ex_result_src = rs; ex_mem_write = mw; ex_funct3 = f3;
    ex_alu_result = alu; ex_rd = rd; ex_rd2 = rd2; ex_pc_cur = pc;
    ex_valid = 1; wb_ready = 1;
    while (!ex_ready && waits < 50) begin step; waits++; end
    if (!ex_ready) begin chk("accept_wait", 0, 1); ex_valid = 0; return; end
    step; ex_valid = 0;
    res_chk = !mem || (!mw && !tmo && !mis);
    if (!mem) begin
      e_res = (rs == 2'b10) ? pc + 32'd4 : alu;
      e_rw = rw;
    end else if (mis) begin
      chk("mis_no_req", dmem_req, 0);
    end else begin
      chk("addr", dmem_addr, alu & 32'hFFFF_FFFC);
      chk("be", dmem_be, m_be(f3, off));
      chk("we", dmem_we, mw);
      if (mw) chk("wdata", dmem_wdata, m_wdata(f3, rd2));
      n = tmo ? MAX_WAIT : dly;
      for (int i = 1; i <= n; i++) begin
        chk("req_hold", dmem_req, 1);
        chk("ex_ready_access", ex_ready, 0);
        chk("addr_hold", dmem_addr, alu & 32'hFFFF_FFFC);
        if (i == n && !tmo) begin dmem_ack = 1; dmem_rdata = rdata; end
        step;
        dmem_ack = 0; dmem_rdata = $urandom;
      end
      chk("req_drop", dmem_req, 0);
      e_rw = (!tmo && !mw) ? rw : 1'b0;
      if (res_chk) e_res = m_load(f3, off, rdata);
    end
    chk("wb_valid", wb_valid, 1);
    chk("wb_rd", wb_rd, rd);
    chk("wb_reg_write", wb_reg_write, e_rw);
    chk("wb_timeout", wb_timeout, tmo && !mis);
    if (res_chk) chk("wb_result", wb_result, e_res);
`ifdef MISALIGN_TRAP_EN
    chk("wb_misalign", wb_misalign, mis);
`endif
    wb_ready = 0;
    for (int i = 0; i < stall; i++) begin
      step;
      chk("stall_valid", wb_valid, 1);
      chk("stall_rd", wb_rd, rd);
      chk("stall_ex_ready", ex_ready, 0);
      if (res_chk) chk("stall_result", wb_result, e_res);
    end
    wb_ready = 1;
    chk("ex_ready_release", ex_ready, !mem);
    step;
    chk("wb_drop", wb_valid, 0);
    chk("ex_ready_idle", ex_ready, 1);
  endtask

  initial begin
    logic [2:0] f3s [5];
    f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    step; step;
    chk("rst_valid", wb_valid, 0);
    chk("rst_req", dmem_req, 0);
    reset = 0;
    chk("rst_ex_ready", ex_ready, 1);

    // directed cases
    do_op(1, 2'b00, 0, 3'b010, 32'h1234, 5'd5, 0, 0, 1, 0, 0);
    do_op(1, 2'b01, 0, 3'b000, 32'h103, 5'd7, 0, 0, 2, 32'h80FF_0000, 1);
    do_op(0, 2'b00, 1, 3'b001, 32'h202, 5'd0, 32'hABCD, 0, 1, 0, 0);
    do_op(1, 2'b10, 0, 3'b010, 0, 5'd1, 0, 32'hFFFF_FFFC, 1, 0, 0);
    do_op(1, 2'b01, 0, 3'b010, 32'h300, 5'd9, 0, 0, MAX_WAIT + 1, 0, 4);
`ifdef MISALIGN_TRAP_EN
    do_op(1, 2'b01, 0, 3'b010, 32'h2, 5'd3, 0, 0, 1, 0, 1);
`endif

    // back-to-back non-memory ops, one per cycle
    wb_ready = 1; ex_result_src = 2'b00; ex_mem_write = 0; ex_reg_write = 1;
    for (int k = 0; k < 3; k++) begin
      ex_alu_result = 32'h100 + 32'(k) * 32'h11; ex_rd = 5'(k + 1); ex_valid = 1;
      chk("stream_ready", ex_ready, 1);
      step;
      chk("stream_valid", wb_valid, 1);
      chk("stream_result", wb_result, 32'h100 + 32'(k) * 32'h11);
    end
    ex_valid = 0; step;
    chk("stream_drop", wb_valid, 0);

    // randomized mix
    for (int t = 0; t < 60; t++) begin
      logic [1:0] rs = 2'($urandom_range(0, 2));
      logic mw = (rs != 2'b01) && ($urandom_range(0, 2) == 0);
      int dly = ($urandom_range(0, 7) == 0) ? MAX_WAIT + 1 : int'($urandom_range(1, 6));
      do_op(1'($urandom), rs, mw, f3s[$urandom_range(0, 4)], $urandom, 5'($urandom),
            $urandom, $urandom, dly, $urandom, int'($urandom_range(0, 3)));
    end

    // reset in the middle of an access, then a late ack
    ex_reg_write = 1; ex_result_src = 2'b01; ex_mem_write = 0; ex_funct3 = 3'b010;
    ex_alu_result = 32'h40; ex_valid = 1;
    step; ex_valid = 0;
    step;
    chk("mid_req", dmem_req, 1);
    reset = 1; step;
    chk("mid_rst_req", dmem_req, 0);
    chk("mid_rst_valid", wb_valid, 0);
    reset = 0;
    chk("post_rst_ready", ex_ready, 1);
    dmem_ack = 1; step; dmem_ack = 0;
    chk("late_ack_valid", wb_valid, 0);
    chk("late_ack_req", dmem_req, 0);
    step;
    chk("late_ack_valid2", wb_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
